// File: rtl/msk_rnd_pkg.sv
// Shared constants and types for the masking randomness source.
package msk_rnd_pkg;

  // LFSR geometry and feedback taps
  localparam int LFSR_W = 128;
  localparam int TAP_A  = 127;
  localparam int TAP_B  = 6;
  localparam int TAP_C  = 1;
  localparam int TAP_D  = 0;

  // Seed interface: the LFSR is filled with four 32-bit words
  localparam int SEED_W     = 32;
  localparam int SEED_BEATS = LFSR_W / SEED_W;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WARMUP,
    RUN
  } state_t;

endpackage

// File: rtl/msk_lfsr_step.sv
// Combinational N_RND-step advance of the 128-bit fresh-randomness LFSR.
// Kept standalone so gadget-level models can reuse the exact same function.
module msk_lfsr_step
  import msk_rnd_pkg::*;
#(
  parameter int N_RND = 8
) (
  input  logic [LFSR_W-1:0] s_in,
  output logic [LFSR_W-1:0] s_out
);

  // Unroll N_RND single-bit shifts, each feeding back the XOR of the four taps
  always_comb begin
    s_out = s_in;
    for (int i = 0; i < N_RND; i++) begin
      s_out = {s_out[LFSR_W-2:0],
               s_out[TAP_A] ^ s_out[TAP_B] ^ s_out[TAP_C] ^ s_out[TAP_D]};
    end
  end

endmodule

// File: rtl/msk_rnd_src.sv
// Fresh-randomness source for masked gadgets: seeded LFSR with a four-beat
// seed load, a fixed warm-up run, and a valid/ready advance interface.
module msk_rnd_src
  import msk_rnd_pkg::*;
#(
  parameter int N_RND  = 8,
  parameter int WARMUP = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_start,
  input  logic             seed_valid,
  input  logic [31:0]      seed_data,
  output logic             seed_ready,
  input  logic             rnd_ready,
  output logic [N_RND-1:0] rnd,
  output logic             rnd_valid
);

  // Last warm counter value before release; unused when WARMUP is 0
  localparam logic [7:0] WARM_LAST = (WARMUP > 0) ? 8'(WARMUP - 1) : 8'd0;
  localparam logic [1:0] BEAT_LAST = 2'(SEED_BEATS - 1);

  state_t              state;
  state_t              state_nxt;
  logic [LFSR_W-1:0]   lfsr;
  logic [LFSR_W-1:0]   lfsr_adv;
  logic [LFSR_W-1:0]   lfsr_loaded;
  logic [1:0]          beat;
  logic [7:0]          warm;
  logic                beat_last;

  assign beat_last = (beat == BEAT_LAST);

  msk_lfsr_step #(
    .N_RND (N_RND)
  ) u_step (
    .s_in  (lfsr),
    .s_out (lfsr_adv)
  );

  // Merge the incoming seed word into its slot; an all-zero final image gets bit 0 forced
  always_comb begin
    lfsr_loaded = lfsr;
    lfsr_loaded[SEED_W*beat +: SEED_W] = seed_data;
    if (beat_last && (lfsr_loaded == '0)) begin
      lfsr_loaded[0] = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a reseed request overrides everything else
  always_comb begin
    state_nxt = state;
    if (seed_start) begin
      state_nxt = LOAD;
    end else begin
      case (state)
        IDLE: state_nxt = IDLE;
        LOAD: begin
          if (seed_valid && beat_last) begin
            state_nxt = (WARMUP == 0) ? RUN : msk_rnd_pkg::WARMUP;
          end
        end
        msk_rnd_pkg::WARMUP: begin
          if (warm == WARM_LAST) begin
            state_nxt = RUN;
          end
        end
        RUN:     state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // LFSR contents and the beat / warm-up counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= '0;
      beat <= '0;
      warm <= '0;
    end else if (seed_start) begin
      beat <= '0;
      warm <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (seed_valid) begin
            lfsr <= lfsr_loaded;
            beat <= beat + 2'd1;
            warm <= '0;
          end
        end
        msk_rnd_pkg::WARMUP: begin
          lfsr <= lfsr_adv;
          warm <= warm + 8'd1;
        end
        RUN: begin
          if (rnd_ready) begin
            lfsr <= lfsr_adv;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs depend only on registered state, so no input reaches them combinationally
  always_comb begin
    seed_ready = (state == LOAD);
    rnd_valid  = (state == RUN);
    rnd        = '0;
    if (state == RUN) begin
      rnd = lfsr[N_RND-1:0];
    end
  end

endmodule
